// File: rtl/axi_lite_ram_bridge.sv
// AXI4-Lite slave bridging BusMatrix transactions onto the Ram request-pulse interface.
// One transaction in flight; AW, W and AR each have a one-deep holding register.
module axi_lite_ram_bridge #(
    parameter int TIMEOUT = 64
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        i_awValid,
    output logic        o_awReady,
    input  logic [63:0] i_awAddr,
    input  logic        i_wValid,
    output logic        o_wReady,
    input  logic [63:0] i_wData,
    input  logic [7:0]  i_wStrb,
    output logic        o_bValid,
    input  logic        i_bReady,
    output logic [1:0]  o_bResp,
    input  logic        i_arValid,
    output logic        o_arReady,
    input  logic [63:0] i_arAddr,
    output logic        o_rValid,
    input  logic        i_rReady,
    output logic [63:0] o_rData,
    output logic [1:0]  o_rResp,
    output logic [63:0] o_ramWriteAddr,
    output logic [63:0] o_ramWriteData,
    output logic [3:0]  o_ramWriteStrb,
    output logic [63:0] o_ramReadAddr,
    input  logic [63:0] i_ramReadData,
    input  logic        i_ramReadReady,
    input  logic        i_ramWriteReady
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP
    } state_t;

    state_t        r_state, w_nextState;
    logic          r_awHeld, r_wHeld, r_arHeld;
    logic          r_awReady, r_wReady, r_arReady;
    logic [63:0]   r_awAddr, r_wData, r_arAddr;
    logic [7:0]    r_wStrb;
    logic [63:0]   r_txAddr, r_txData, r_rData;
    logic [3:0]    r_txCode, w_sizeCode;
    logic [1:0]    r_resp;
    logic          r_lastGrantWrite;
    logic [CW-1:0] r_count;
    logic          w_awFire, w_wFire, w_arFire;
    logic          w_grantWrite, w_grantRead, w_writeBad, w_timeout, w_contention;

    assign w_awFire     = i_awValid & r_awReady;
    assign w_wFire      = i_wValid & r_wReady;
    assign w_arFire     = i_arValid & r_arReady;
    assign w_timeout    = (r_count == LAST);
    assign w_contention = r_awHeld & r_wHeld & r_arHeld;
    assign w_writeBad   = (w_sizeCode == 4'd0) | (r_awAddr == '0);

    assign o_awReady = r_awReady;
    assign o_wReady  = r_wReady;
    assign o_arReady = r_arReady;
    assign o_bResp   = o_bValid ? r_resp : 2'b00;
    assign o_rResp   = o_rValid ? r_resp : 2'b00;
    assign o_rData   = o_rValid ? r_rData : 64'd0;

    always_comb begin
        case (r_wStrb)
            8'h01:   w_sizeCode = 4'd1;
            8'h03:   w_sizeCode = 4'd2;
            8'h0F:   w_sizeCode = 4'd4;
            8'hFF:   w_sizeCode = 4'd8;
            default: w_sizeCode = 4'd0;
        endcase
    end

    // Ram buses are only ever driven from the single REQ cycle, so requests are one-cycle pulses.
    always_comb begin
        w_nextState    = r_state;
        w_grantWrite   = 1'b0;
        w_grantRead    = 1'b0;
        o_bValid       = 1'b0;
        o_rValid       = 1'b0;
        o_ramWriteAddr = 64'd0;
        o_ramWriteData = 64'd0;
        o_ramWriteStrb = 4'd0;
        o_ramReadAddr  = 64'd0;
        case (r_state)
            IDLE: begin
                if (r_awHeld && r_wHeld && (!r_arHeld || !r_lastGrantWrite)) begin
                    w_grantWrite = 1'b1;
                    w_nextState  = w_writeBad ? WR_RESP : WR_REQ;
                end else if (r_arHeld) begin
                    w_grantRead = 1'b1;
                    w_nextState = (r_arAddr == '0) ? RD_RESP : RD_REQ;
                end
            end
            WR_REQ: begin
                o_ramWriteAddr = r_txAddr;
                o_ramWriteData = r_txData;
                o_ramWriteStrb = r_txCode;
                w_nextState    = WR_WAIT;
            end
            WR_WAIT: begin
                if (i_ramWriteReady || w_timeout) w_nextState = WR_RESP;
            end
            WR_RESP: begin
                o_bValid = 1'b1;
                if (i_bReady) w_nextState = IDLE;
            end
            RD_REQ: begin
                o_ramReadAddr = r_txAddr;
                w_nextState   = RD_WAIT;
            end
            RD_WAIT: begin
                if (i_ramReadReady || w_timeout) w_nextState = RD_RESP;
            end
            RD_RESP: begin
                o_rValid = 1'b1;
                if (i_rReady) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state          <= IDLE;
            r_awHeld         <= 1'b0;
            r_wHeld          <= 1'b0;
            r_arHeld         <= 1'b0;
            r_awReady        <= 1'b0;
            r_wReady         <= 1'b0;
            r_arReady        <= 1'b0;
            r_awAddr         <= 64'd0;
            r_wData          <= 64'd0;
            r_wStrb          <= 8'd0;
            r_arAddr         <= 64'd0;
            r_txAddr         <= 64'd0;
            r_txData         <= 64'd0;
            r_txCode         <= 4'd0;
            r_rData          <= 64'd0;
            r_resp           <= 2'b00;
            r_lastGrantWrite <= 1'b0;
            r_count          <= '0;
        end else begin
            r_state <= w_nextState;

            if (w_awFire) begin
                r_awHeld <= 1'b1;
                r_awAddr <= i_awAddr;
            end else if (w_grantWrite) begin
                r_awHeld <= 1'b0;
            end
            if (w_wFire) begin
                r_wHeld <= 1'b1;
                r_wData <= i_wData;
                r_wStrb <= i_wStrb;
            end else if (w_grantWrite) begin
                r_wHeld <= 1'b0;
            end
            if (w_arFire) begin
                r_arHeld <= 1'b1;
                r_arAddr <= i_arAddr;
            end else if (w_grantRead) begin
                r_arHeld <= 1'b0;
            end
            r_awReady <= !(w_awFire | (r_awHeld & !w_grantWrite));
            r_wReady  <= !(w_wFire | (r_wHeld & !w_grantWrite));
            r_arReady <= !(w_arFire | (r_arHeld & !w_grantRead));

            // Arbitration history only moves when both sides were actually competing.
            if (w_grantWrite) begin
                r_txAddr <= r_awAddr;
                r_txData <= r_wData;
                r_txCode <= w_sizeCode;
                if (w_writeBad) r_resp <= 2'b10;
                if (w_contention) r_lastGrantWrite <= 1'b1;
            end
            if (w_grantRead) begin
                r_txAddr <= r_arAddr;
                if (r_arAddr == '0) begin
                    r_resp  <= 2'b10;
                    r_rData <= 64'd0;
                end
                if (w_contention) r_lastGrantWrite <= 1'b0;
            end

            if (r_state == WR_REQ || r_state == RD_REQ) begin
                r_count <= '0;
            end else if ((r_state == WR_WAIT || r_state == RD_WAIT) && !w_timeout) begin
                r_count <= r_count + 1'b1;
            end

            if (r_state == WR_WAIT) begin
                if (i_ramWriteReady) r_resp <= 2'b00;
                else if (w_timeout) r_resp <= 2'b10;
            end
            if (r_state == RD_WAIT) begin
                if (i_ramReadReady) begin
                    r_rData <= i_ramReadData;
                    r_resp  <= 2'b00;
                end else if (w_timeout) begin
                    r_rData <= 64'd0;
                    r_resp  <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_ram_bridge.sv
// Randomised self-checking bench for axi_lite_ram_bridge; the bench plays both the bus master
// and the Ram, and predicts each response from the transaction fields alone.
module tb_axi_lite_ram_bridge;

    localparam int TIMEOUT = 16;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        awValid = 1'b0, wValid = 1'b0, arValid = 1'b0, bReady = 1'b0, rReady = 1'b0;
    logic        awReady, wReady, arReady, bValid, rValid;
    logic [63:0] awAddr = '0, wData = '0, arAddr = '0;
    logic [7:0]  wStrb = '0;
    logic [1:0]  bResp, rResp;
    logic [63:0] rData, ramWA, ramWD, ramRA;
    logic [3:0]  ramWS;
    logic [63:0] ramReadData = '0;
    logic        ramReadReady = 1'b0, ramWriteReady = 1'b0;

    int checkCount = 0;
    int passCount = 0;
    int exclViol = 0;
    int widthViol = 0;
    logic [63:0] prevWA = '0, prevRA = '0;
    bit modelLastWrite = 1'b0;

    axi_lite_ram_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .i_awValid(awValid), .o_awReady(awReady), .i_awAddr(awAddr),
        .i_wValid(wValid), .o_wReady(wReady), .i_wData(wData), .i_wStrb(wStrb),
        .o_bValid(bValid), .i_bReady(bReady), .o_bResp(bResp),
        .i_arValid(arValid), .o_arReady(arReady), .i_arAddr(arAddr),
        .o_rValid(rValid), .i_rReady(rReady), .o_rData(rData), .o_rResp(rResp),
        .o_ramWriteAddr(ramWA), .o_ramWriteData(ramWD), .o_ramWriteStrb(ramWS),
        .o_ramReadAddr(ramRA), .i_ramReadData(ramReadData),
        .i_ramReadReady(ramReadReady), .i_ramWriteReady(ramWriteReady)
    );

    always #5 ACLK = ~ACLK;

    // Continuous watch on the Ram side: never both requests at once, never a request two cycles wide.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (ramWA != '0 && ramRA != '0) exclViol++;
            if ((ramWA != '0 && prevWA != '0) || (ramRA != '0 && prevRA != '0)) widthViol++;
        end
        prevWA = ramWA;
        prevRA = ramRA;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // A legal strobe is a contiguous low mask of 1, 2, 4 or 8 bytes; its size code is the byte count.
    function automatic logic [3:0] expectedCode(input logic [7:0] strb);
        int n = $countones(strb);
        if ((n == 1 || n == 2 || n == 4 || n == 8) && strb == 8'((1 << n) - 1)) return 4'(n);
        return 4'd0;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Handshake"}, 64'({awReady, wReady, arReady, bValid, rValid, bResp, rResp}), 64'd0);
        checkOutput({tag, "Buses"}, ramWA | ramWD | ramRA | rData, 64'd0);
        checkOutput({tag, "Strb"}, 64'(ramWS), 64'd0);
    endtask

    task automatic handshakeWrite(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                                  input int awDelay, input int wDelay, output bit ok);
        bit awFire = 1'b0, wFire = 1'b0, awDone = 1'b0, wDone = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge ACLK);
            if (awFire) begin awValid = 1'b0; awDone = 1'b1; end
            if (wFire) begin wValid = 1'b0; wDone = 1'b1; end
            if (awDone && wDone) begin ok = 1'b1; break; end
            if (!awDone && k >= awDelay) begin awValid = 1'b1; awAddr = addr; end
            if (!wDone && k >= wDelay) begin wValid = 1'b1; wData = data; wStrb = strb; end
            awFire = awValid && awReady;
            wFire  = wValid && wReady;
        end
        awValid = 1'b0;
        wValid = 1'b0;
        if (!ok) checkOutput("wrHandshake", 64'd0, 64'd1);
    endtask

    task automatic writeTxn(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input int lat, input int hold);
        logic [3:0]  code = expectedCode(strb);
        bit          expErr = (addr == '0) || (code == 4'd0);
        logic [1:0]  expResp = (expErr || lat < 0) ? 2'b10 : 2'b00;
        int          reqCount = 0, reqCyc = -1, pulseCyc = -1, bCyc = -1;
        logic [63:0] gotAddr = '0, gotData = '0;
        logic [3:0]  gotStrb = '0;
        bit          ok;
        handshakeWrite(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 2), ok);
        if (!ok) return;
        for (int cyc = 0; cyc < TIMEOUT + 20; cyc++) begin
            @(negedge ACLK);
            ramWriteReady = 1'b0;
            if (ramWA != '0) begin
                reqCount++;
                reqCyc = cyc;
                gotAddr = ramWA;
                gotData = ramWD;
                gotStrb = ramWS;
                if (lat >= 0) pulseCyc = cyc + 1 + lat;
            end
            if (cyc == pulseCyc) ramWriteReady = 1'b1;
            if (bValid) begin bCyc = cyc; break; end
        end
        ramWriteReady = 1'b0;
        if (bCyc < 0) begin
            checkOutput("wrBvalidTimeout", 64'd0, 64'd1);
            return;
        end
        if (expErr) begin
            checkOutput("wrNoRamReq", 64'(reqCount), 64'd0);
        end else begin
            checkOutput("wrReqCount", 64'(reqCount), 64'd1);
            checkOutput("wrRamAddr", gotAddr, addr);
            checkOutput("wrRamData", gotData, data);
            checkOutput("wrRamStrb", 64'(gotStrb), 64'(code));
            checkOutput("wrLatency", 64'(bCyc - reqCyc), (lat < 0) ? 64'(TIMEOUT + 1) : 64'(lat + 2));
        end
        for (int h = 0; h <= hold; h++) begin
            checkOutput("wrBvalid", 64'(bValid), 64'd1);
            checkOutput("wrBresp", 64'(bResp), 64'(expResp));
            if (h == hold) bReady = 1'b1;
            @(negedge ACLK);
        end
        checkOutput("wrBvalidDrop", 64'(bValid), 64'd0);
        bReady = 1'b0;
    endtask

    task automatic readTxn(input logic [63:0] addr, input logic [63:0] data, input int lat, input int hold);
        bit          expErr = (addr == '0);
        logic [1:0]  expResp = (expErr || lat < 0) ? 2'b10 : 2'b00;
        logic [63:0] expData = (expErr || lat < 0) ? 64'd0 : data;
        int          reqCount = 0, reqCyc = -1, pulseCyc = -1, rCyc = -1;
        logic [63:0] gotAddr = '0;
        bit          arFire = 1'b0, ok = 1'b0;
        int          delay = $urandom_range(0, 2);
        for (int k = 0; k < 30; k++) begin
            @(negedge ACLK);
            if (arFire) begin arValid = 1'b0; ok = 1'b1; break; end
            if (k >= delay) begin arValid = 1'b1; arAddr = addr; end
            arFire = arValid && arReady;
        end
        arValid = 1'b0;
        if (!ok) begin
            checkOutput("rdHandshake", 64'd0, 64'd1);
            return;
        end
        for (int cyc = 0; cyc < TIMEOUT + 20; cyc++) begin
            @(negedge ACLK);
            ramReadReady = 1'b0;
            ramReadData = {$urandom, $urandom};
            if (ramRA != '0) begin
                reqCount++;
                reqCyc = cyc;
                gotAddr = ramRA;
                if (lat >= 0) pulseCyc = cyc + 1 + lat;
            end
            if (cyc == pulseCyc) begin
                ramReadReady = 1'b1;
                ramReadData = data;
            end
            if (rValid) begin rCyc = cyc; break; end
        end
        ramReadReady = 1'b0;
        if (rCyc < 0) begin
            checkOutput("rdRvalidTimeout", 64'd0, 64'd1);
            return;
        end
        if (expErr) begin
            checkOutput("rdNoRamReq", 64'(reqCount), 64'd0);
        end else begin
            checkOutput("rdReqCount", 64'(reqCount), 64'd1);
            checkOutput("rdRamAddr", gotAddr, addr);
            checkOutput("rdLatency", 64'(rCyc - reqCyc), (lat < 0) ? 64'(TIMEOUT + 1) : 64'(lat + 2));
        end
        for (int h = 0; h <= hold; h++) begin
            checkOutput("rdRvalid", 64'(rValid), 64'd1);
            checkOutput("rdRresp", 64'(rResp), 64'(expResp));
            checkOutput("rdRdata", rData, expData);
            ramReadReady = (lat < 0 && h == 0);
            ramReadData = ~data;
            if (h == hold) rReady = 1'b1;
            @(negedge ACLK);
        end
        ramReadReady = 1'b0;
        checkOutput("rdRvalidDrop", 64'(rValid), 64'd0);
        rReady = 1'b0;
        if (lat < 0) begin
            ramReadReady = 1'b1;
            @(negedge ACLK);
            ramReadReady = 1'b0;
            @(negedge ACLK);
            checkOutput("rdStrayRvalid", 64'(rValid), 64'd0);
            checkOutput("rdStrayRamReq", ramRA, 64'd0);
        end
    endtask

    task automatic contend();
        bit          expectWrite = !modelLastWrite;
        int          firstKind = 0, wReq = -1, rReq = -1;
        bit          bSeen = 1'b0, rSeen = 1'b0;
        logic [1:0]  gotB = '0, gotR = '0;
        logic [63:0] gotData = '0;
        logic [63:0] readVal = {$urandom, $urandom};
        @(negedge ACLK);
        checkOutput("contReady", 64'({awReady, wReady, arReady}), 64'd7);
        awValid = 1'b1; awAddr = {$urandom, $urandom} | 64'd1;
        wValid = 1'b1;  wData = {$urandom, $urandom}; wStrb = 8'hFF;
        arValid = 1'b1; arAddr = {$urandom, $urandom} | 64'd1;
        bReady = 1'b1;
        rReady = 1'b1;
        @(negedge ACLK);
        awValid = 1'b0;
        wValid = 1'b0;
        arValid = 1'b0;
        for (int cyc = 0; cyc < 4 * TIMEOUT; cyc++) begin
            @(negedge ACLK);
            ramWriteReady = 1'b0;
            ramReadReady = 1'b0;
            ramReadData = {$urandom, $urandom};
            if (ramWA != '0) begin
                if (firstKind == 0) firstKind = 1;
                wReq = cyc;
            end
            if (ramRA != '0) begin
                if (firstKind == 0) firstKind = 2;
                rReq = cyc;
            end
            if (wReq >= 0 && cyc == wReq + 1) ramWriteReady = 1'b1;
            if (rReq >= 0 && cyc == rReq + 1) begin
                ramReadReady = 1'b1;
                ramReadData = readVal;
            end
            if (bValid) begin bSeen = 1'b1; gotB = bResp; end
            if (rValid) begin rSeen = 1'b1; gotR = rResp; gotData = rData; end
            if (bSeen && rSeen) break;
        end
        @(negedge ACLK);
        ramWriteReady = 1'b0;
        ramReadReady = 1'b0;
        bReady = 1'b0;
        rReady = 1'b0;
        checkOutput("contOrder", 64'(firstKind), expectWrite ? 64'd1 : 64'd2);
        checkOutput("contBothDone", 64'({bSeen, rSeen}), 64'd3);
        checkOutput("contBresp", 64'(gotB), 64'd0);
        checkOutput("contRresp", 64'(gotR), 64'd0);
        checkOutput("contRdata", gotData, readVal);
        modelLastWrite = expectWrite;
    endtask

    task automatic resetDuringWrite();
        bit ok;
        bit seen = 1'b0;
        handshakeWrite(64'h0000_0000_4000_0100, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 0, 0, ok);
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge ACLK);
            seen = (ramWA != '0);
        end
        checkOutput("rstReqSeen", 64'(seen), 64'd1);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b0;
        @(negedge ACLK);
        checkAllZero("rstMid");
        ARESETn = 1'b1;
        @(negedge ACLK);
        checkOutput("rstMidReadyUp", 64'({awReady, wReady, arReady}), 64'd7);
        ramWriteReady = 1'b1;
        @(negedge ACLK);
        ramWriteReady = 1'b0;
        repeat (3) begin
            @(negedge ACLK);
            checkOutput("rstLateNoBvalid", 64'(bValid), 64'd0);
        end
        modelLastWrite = 1'b0;
    endtask

    // One random transaction: legal and illegal strobes, zero addresses and Ram timeouts all appear.
    task automatic applyStimulus();
        logic [7:0]  masks [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};
        logic [63:0] addr = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
        logic [63:0] data = {$urandom, $urandom};
        int          lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
        int          hold = $urandom_range(0, 3);
        int          pick = $urandom_range(0, 4);
        logic [7:0]  strb = (pick == 4) ? 8'($urandom) : masks[pick];
        if ($urandom_range(0, 1) == 1) writeTxn(addr, data, strb, lat, hold);
        else readTxn(addr, data, lat, hold);
    endtask

    initial begin
        repeat (3) @(negedge ACLK);
        checkAllZero("rstInit");
        ARESETn = 1'b1;
        @(negedge ACLK);
        checkOutput("rstReadyUp", 64'({awReady, wReady, arReady}), 64'd7);

        writeTxn(64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 2, 1);
        writeTxn(64'h0000_0000_8000_0020, 64'h0000_0000_0000_00AB, 8'h01, 1, 0);
        writeTxn(64'h0000_0000_8000_0030, 64'h0000_0000_0000_1234, 8'h06, 0, 0);
        writeTxn(64'h0000_0000_0000_0000, 64'h0000_0000_0000_5678, 8'h0F, 0, 0);
        readTxn(64'h0000_0000_8000_0010, 64'h0000_0000_DEAD_BEEF, 3, 5);
        readTxn(64'h0000_0000_0000_0000, 64'h0000_0000_CAFE_F00D, 1, 1);
        contend();
        contend();
        readTxn(64'h0000_0000_8000_0040, 64'h0000_0000_1357_9BDF, -1, 3);
        writeTxn(64'h0000_0000_8000_0050, 64'h0000_0000_2468_ACE0, 8'h03, -1, 1);
        resetDuringWrite();
        contend();

        for (int i = 0; i < 40; i++) applyStimulus();

        checkOutput("ramExclusive", 64'(exclViol), 64'd0);
        checkOutput("ramPulseWidth", 64'(widthViol), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
